cv3_relu_maxpool: RTL and testbench
===================================

Name: cv3_relu_maxpool

Overview:
- Streaming ReLU + 2x2 max-pool stage directly downstream of the 3x3 conv channel.
- Consumes one fp16 output column per valid_in pulse and pools vertical row pairs and horizontal column pairs.
- Emits one pooled column of COL_SIZE/2 values for every second input column.
- No backpressure, valid-only interface, matching the upstream stage.

Parameters:
- DATA_WIDTH, 16, element width (IEEE fp16).
- COL_SIZE, 10, input column length. Must be even.
- COLS_PER_FRAME, 10, input columns per feature map. Must be even and >= 2.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset (asserted when 0).
- valid_in  input  1  input_column is valid this cycle.
- input_column  input  DATA_WIDTH x COL_SIZE  one conv output column; index 0 = top row.
- output_column  output  DATA_WIDTH x COL_SIZE/2  pooled column.
- valid_out  output  1  single-cycle strobe, output_column valid.
- last_out  output  1  qualifies valid_out; marks the final pooled column of a frame.

Behaviour:
- Reset: sampled on clk edge while rst==0.
  - Clears valid_out=0, last_out=0, output_column all 0x0000, hold register all 0x0000, col_cnt=0, phase=EVEN.
  - Reset mid-frame discards the held half-column; the next valid_in is treated as column 0.
- ReLU (with RELU_EN): any element with sign bit set, including -0 and negative NaN, becomes 0x0000. Other elements pass unchanged.
- Vertical max, combinational: v[k] = max(x[2k], x[2k+1]) for k = 0..COL_SIZE/2-1.
- max() with ReLU applied: plain unsigned compare of the 16-bit patterns.
  - Valid because all operands are non-negative.
  - Positive NaN (e.g. 0x7E00) wins over +inf and propagates.
  - Ties select the first operand (lower row index, or earlier column).
- State machine, two states:
  - EVEN: on valid_in, hold <= v; phase -> ODD. No output.
  - ODD: on valid_in, output_column[k] <= max(hold[k], v[k]); valid_out <= 1; phase -> EVEN.
  - No valid_in: state, hold and output_column hold their values; valid_out <= 0.
- Latency: valid_out asserts exactly 1 cycle after the odd-phase valid_in.
  - Back-to-back valid_in every cycle gives valid_out on alternate cycles.
- output_column holds its last value between strobes. Downstream samples it only when valid_out=1.
- col_cnt: 0..COLS_PER_FRAME-1, increments on each valid_in, wraps to 0 after COLS_PER_FRAME-1.
  - last_out <= 1 together with valid_out when the consumed column has col_cnt == COLS_PER_FRAME-1; otherwise 0.
  - At wrap, phase returns to EVEN, so frames never straddle a pool window.
- Gaps: arbitrary idle cycles between valid_in pulses are legal and change nothing.
- Width: elements are never widened or rounded; the output is always one of the input bit patterns (or 0x0000 from ReLU).

Optional Feature:
- Macro: CV3_POOL_RELU_EN.
- Defined: ReLU applied before pooling; unsigned comparator as above.
- Undefined: ReLU omitted; max() uses a signed fp16 ordering:
  - Signs differ: the non-negative operand wins. +0 beats -0.
  - Both non-negative: the larger bit pattern wins.
  - Both negative: the smaller magnitude bit pattern wins.
  - NaN: treated by its raw bit pattern under these same rules.
  - Ties: the first operand wins.
  - Output values can be negative.

Test Plan:
- Reset and idle: rst=0 for 2 cycles, then rst=1 with no valid_in for 5 cycles -> valid_out=0, last_out=0, output_column all 0x0000 throughout.
- Basic pool (COL_SIZE=10, RELU_EN defined):
  - Stimulus: col0 all 0x3C00 (1.0) except row1=0x4000 (2.0); col1 all 0x3800 (0.5) except row3=0x4200 (3.0).
  - Response: one strobe 1 cycle after col1, with out[0]=0x4000, out[1]=0x4200, out[2..4]=0x3C00; last_out=0.
- ReLU clamp: both columns all 0xBC00 (-1.0) -> out all 0x0000. With macro undefined, out all 0xBC00.
- Frame wrap:
  - Stimulus: 10 columns back-to-back, then 10 more with 3 idle cycles between each.
  - Response: exactly 10 valid_out strobes; last_out=1 only on the 5th and 10th strobes; strobe spacing 2 cycles in frame 1.
- Reset mid-frame: 3 columns in, rst=0 for 1 cycle, then 2 columns in -> exactly 1 strobe after the reset, equal to the pooled max of those 2 post-reset columns only.
- Ties and NaN: col0 row0=0x7E00 (positive NaN), col1 row0=0x7C00 (+inf) -> out[0]=0x7E00. Identical columns of 0x3C00 -> out all 0x3C00.

Source files
------------

// File: rtl/cv3_relu_maxpool_if.sv
// rtl/cv3_relu_maxpool_if.sv - valid-only column stream between the conv channel and the pooling stage
interface cv3_relu_maxpool_if #(
    parameter int DATA_WIDTH = 16,
    parameter int COL_SIZE   = 10
);
    logic                                   valid_in;
    logic [COL_SIZE-1:0][DATA_WIDTH-1:0]    input_column;
    logic [COL_SIZE/2-1:0][DATA_WIDTH-1:0]  output_column;
    logic                                   valid_out;
    logic                                   last_out;

    modport master (
        output valid_in,
        output input_column,
        input  output_column,
        input  valid_out,
        input  last_out
    );

    modport slave (
        input  valid_in,
        input  input_column,
        output output_column,
        output valid_out,
        output last_out
    );
endinterface

// File: rtl/cv3_relu_maxpool.sv
// rtl/cv3_relu_maxpool.sv - streaming ReLU + 2x2 max-pool over fp16 columns (ReLU under CV3_POOL_RELU_EN)
module cv3_relu_maxpool #(
    parameter int DATA_WIDTH     = 16,
    parameter int COL_SIZE       = 10,
    parameter int COLS_PER_FRAME = 10
) (
    input  logic              clk,
    input  logic              rst,
    cv3_relu_maxpool_if.slave bus
);
    localparam int HALF = COL_SIZE / 2;
    localparam int CW   = (COLS_PER_FRAME > 2) ? $clog2(COLS_PER_FRAME) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(COLS_PER_FRAME - 1);

    typedef logic [DATA_WIDTH-1:0] elem_t;
    typedef enum logic {EVEN, ODD} phase_t;

    phase_t                 phase;
    logic [CW-1:0]          col_cnt;
    logic [HALF-1:0][DATA_WIDTH-1:0] hold;
    logic [HALF-1:0][DATA_WIDTH-1:0] vmax;
    logic [HALF-1:0][DATA_WIDTH-1:0] pooled;

    function automatic elem_t relu(input elem_t x);
`ifdef CV3_POOL_RELU_EN
        relu = x[DATA_WIDTH-1] ? '0 : x;
`else
        relu = x;
`endif
    endfunction

    // True when a is kept over b; equality keeps a so ties favour the earlier operand.
    function automatic logic first_wins(input elem_t a, input elem_t b);
`ifdef CV3_POOL_RELU_EN
        first_wins = (a >= b);
`else
        if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
            first_wins = ~a[DATA_WIDTH-1];
        else if (!a[DATA_WIDTH-1])
            first_wins = (a >= b);
        else
            first_wins = (a <= b);
`endif
    endfunction

    function automatic elem_t max2(input elem_t a, input elem_t b);
        max2 = first_wins(a, b) ? a : b;
    endfunction

    always_comb begin
        vmax   = '0;
        pooled = '0;
        for (int k = 0; k < HALF; k++) begin
            vmax[k]   = max2(relu(bus.input_column[2*k]), relu(bus.input_column[2*k+1]));
            pooled[k] = max2(hold[k], vmax[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase             <= EVEN;
            col_cnt           <= '0;
            hold              <= '0;
            bus.output_column <= '0;
            bus.valid_out     <= 1'b0;
            bus.last_out      <= 1'b0;
        end else begin
            bus.valid_out <= 1'b0;
            bus.last_out  <= 1'b0;
            if (bus.valid_in) begin
                col_cnt <= (col_cnt == LAST_COL) ? '0 : col_cnt + 1'b1;
                case (phase)
                    EVEN: begin
                        hold  <= vmax;
                        phase <= ODD;
                    end
                    ODD: begin
                        bus.output_column <= pooled;
                        bus.valid_out     <= 1'b1;
                        bus.last_out      <= (col_cnt == LAST_COL);
                        phase             <= EVEN;
                    end
                    default: phase <= EVEN;
                endcase
                // A frame boundary always closes the pool window.
                if (col_cnt == LAST_COL)
                    phase <= EVEN;
            end
        end
    end
endmodule

// File: tb/tb_cv3_relu_maxpool.sv
// tb/tb_cv3_relu_maxpool.sv - self-checking bench for cv3_relu_maxpool
module tb_cv3_relu_maxpool;
    localparam int DW   = 16;
    localparam int CS   = 10;
    localparam int CPF  = 10;
    localparam int HALF = CS / 2;

    typedef logic [CS-1:0][DW-1:0]   col_t;
    typedef logic [HALF-1:0][DW-1:0] out_t;
    typedef struct {
        string name;
        col_t  c0;
        col_t  c1;
        out_t  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cv3_relu_maxpool_if #(.DATA_WIDTH(DW), .COL_SIZE(CS)) bus();
    cv3_relu_maxpool #(.DATA_WIDTH(DW), .COL_SIZE(CS), .COLS_PER_FRAME(CPF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    out_t   sq[$];
    logic   lq[$];
    int     cq[$];
    out_t   exp_q[$];
    logic   exp_last_q[$];
    int     odd_cap_q[$];
    col_t   pend;
    int     mcnt = 0;

    always @(negedge clk) begin
        if (bus.valid_out) begin
            sq.push_back(bus.output_column);
            lq.push_back(bus.last_out);
            cq.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ordering key: larger key is the larger value; negatives sit below every non-negative.
    function automatic int key(input logic [15:0] p);
`ifdef CV3_POOL_RELU_EN
        key = p[15] ? 0 : int'(p);
`else
        key = p[15] ? -int'(p[14:0]) - 1 : int'(p);
`endif
    endfunction

    function automatic logic [15:0] relu_val(input logic [15:0] p);
`ifdef CV3_POOL_RELU_EN
        relu_val = p[15] ? 16'h0000 : p;
`else
        relu_val = p;
`endif
    endfunction

    function automatic out_t pool(input col_t a, input col_t b);
        logic [15:0] cand[4];
        logic [15:0] best;
        for (int k = 0; k < HALF; k++) begin
            cand[0] = relu_val(a[2*k]);
            cand[1] = relu_val(a[2*k+1]);
            cand[2] = relu_val(b[2*k]);
            cand[3] = relu_val(b[2*k+1]);
            best = cand[0];
            for (int j = 1; j < 4; j++)
                if (key(cand[j]) > key(best)) best = cand[j];
            pool[k] = best;
        end
    endfunction

    function automatic col_t fill(input logic [15:0] v);
        for (int i = 0; i < CS; i++) fill[i] = v;
    endfunction

    function automatic col_t rnd_col();
        logic [15:0] specials[5];
        specials[0] = 16'h7E00; specials[1] = 16'h7C00; specials[2] = 16'h8000;
        specials[3] = 16'h0000; specials[4] = 16'hFE00;
        for (int i = 0; i < CS; i++)
            rnd_col[i] = ($urandom_range(0, 5) == 0) ? specials[$urandom_range(0, 4)] : 16'($urandom);
    endfunction

    task automatic flush();
        sq.delete(); lq.delete(); cq.delete();
        exp_q.delete(); exp_last_q.delete(); odd_cap_q.delete();
    endtask

    task automatic do_reset(input int n);
        bus.valid_in = 1'b0;
        rst = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
        rst = 1'b1;
        mcnt = 0;
        flush();
    endtask

    task automatic send(input col_t c, input int gap);
        logic odd;
        odd = (mcnt % 2) == 1;
        bus.valid_in = 1'b1;
        bus.input_column = c;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        if (odd) begin
            exp_q.push_back(pool(pend, c));
            exp_last_q.push_back(mcnt == CPF - 1);
            odd_cap_q.push_back(cyc);
        end else begin
            pend = c;
        end
        mcnt = (mcnt + 1) % CPF;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic compare_stream(input string name);
        chk({name, "_count"}, 160'(sq.size()), 160'(exp_q.size()));
        for (int i = 0; i < sq.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_data%0d", name, i), 160'(sq[i]), 160'(exp_q[i]));
            chk($sformatf("%s_last%0d", name, i), 160'(lq[i]), 160'(exp_last_q[i]));
            chk($sformatf("%s_lat%0d", name, i), 160'(cq[i]), 160'(odd_cap_q[i]));
        end
    endtask

    vec_t tbl[4];

    initial begin
        bus.valid_in = 1'b0;
        bus.input_column = '0;

        tbl[0].name = "basic";
        tbl[0].c0 = fill(16'h3C00); tbl[0].c0[1] = 16'h4000;
        tbl[0].c1 = fill(16'h3800); tbl[0].c1[3] = 16'h4200;
        tbl[0].exp = {16'h3C00, 16'h3C00, 16'h3C00, 16'h4200, 16'h4000};
        tbl[1].name = "clamp";
        tbl[1].c0 = fill(16'hBC00);
        tbl[1].c1 = fill(16'hBC00);
`ifdef CV3_POOL_RELU_EN
        tbl[1].exp = '0;
`else
        tbl[1].exp = {HALF{16'hBC00}};
`endif
        tbl[2].name = "nan";
        tbl[2].c0 = '0; tbl[2].c0[0] = 16'h7E00;
        tbl[2].c1 = '0; tbl[2].c1[0] = 16'h7C00;
        tbl[2].exp = '0; tbl[2].exp[0] = 16'h7E00;
        tbl[3].name = "ties";
        tbl[3].c0 = fill(16'h3C00);
        tbl[3].c1 = fill(16'h3C00);
        tbl[3].exp = {HALF{16'h3C00}};

        // Reset held, then idle
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_valid", 160'(bus.valid_out), 160'(0));
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("idle_valid%0d", i), 160'(bus.valid_out), 160'(0));
            chk($sformatf("idle_last%0d", i), 160'(bus.last_out), 160'(0));
            chk($sformatf("idle_out%0d", i), 160'(bus.output_column), 160'(0));
        end

        // Table-driven column pairs
        for (int t = 0; t < 4; t++) begin
            sq.delete(); lq.delete(); cq.delete();
            send(tbl[t].c0, 0);
            send(tbl[t].c1, 2);
            chk({tbl[t].name, "_count"}, 160'(sq.size()), 160'(1));
            if (sq.size() > 0) begin
                chk({tbl[t].name, "_data"}, 160'(sq[0]), 160'(tbl[t].exp));
                chk({tbl[t].name, "_last"}, 160'(lq[0]), 160'(0));
            end
        end

        // Frame wrap: one frame back-to-back, one frame with 3 idle cycles per column
        do_reset(1);
        for (int i = 0; i < CPF; i++) send(rnd_col(), 0);
        for (int i = 0; i < CPF; i++) send(rnd_col(), 3);
        repeat (3) begin @(posedge clk); #1; end
        chk("wrap_strobes", 160'(sq.size()), 160'(10));
        for (int i = 0; i < sq.size(); i++)
            chk($sformatf("wrap_last%0d", i), 160'(lq[i]), 160'(i == 4 || i == 9));
        for (int i = 0; i < 4 && i + 1 < cq.size(); i++)
            chk($sformatf("wrap_space%0d", i), 160'(cq[i+1] - cq[i]), 160'(2));
        compare_stream("wrap");

        // Reset mid-frame discards the held half-column
        flush();
        for (int i = 0; i < 3; i++) send(rnd_col(), 0);
        chk("mid_pre_strobes", 160'(sq.size()), 160'(1));
        do_reset(1);
        chk("mid_rst_out", 160'(bus.output_column), 160'(0));
        send(rnd_col(), 1);
        send(rnd_col(), 3);
        compare_stream("mid");

        // Random columns and gaps across two frames
        do_reset(1);
        for (int i = 0; i < 2 * CPF; i++) send(rnd_col(), $urandom_range(0, 2));
        repeat (3) begin @(posedge clk); #1; end
        compare_stream("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
